// File: rtl/csr_ctrl.sv
// csr_ctrl: machine-mode CSR initiator that runs Zicsr read-modify-writes and the trap/MRET update sequences.
//   clk, rst                    clock; asynchronous active-low reset
//   req_*/op_i/csr_addr_i/rs1_* CSR instruction request (accepted only when req_ready_o)
//   resp_*                      one-cycle result: old CSR value and illegal flag
//   trap_*/mret_i               trap entry and MRET requests
//   redirect_*                  one-cycle PC redirect pulse
//   csr_we_o/waddr/wdata        CSR file write port, address/data zero when not writing
//   csr_raddr_o/csr_rdata_i     CSR file combinational read port
module csr_ctrl #(
  parameter int XLEN = 64,
  parameter int CSR_AW = 12,
  parameter logic [CSR_AW-1:0] A_MSTATUS = 12'h300,
  parameter logic [CSR_AW-1:0] A_MTVEC = 12'h305,
  parameter logic [CSR_AW-1:0] A_MEPC = 12'h341,
  parameter logic [CSR_AW-1:0] A_MCAUSE = 12'h342,
  parameter logic [CSR_AW-1:0] A_MTVAL = 12'h343
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        op_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [4:0]        rs1_idx_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_illegal_o,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic [XLEN-1:0]   trap_tval_i,
  input  logic              mret_i,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_EXEC    = 4'd1;
  localparam logic [3:0] S_DONE    = 4'd2;
  localparam logic [3:0] S_T_EPC   = 4'd3;
  localparam logic [3:0] S_T_CAUSE = 4'd4;
  localparam logic [3:0] S_T_TVAL  = 4'd5;
  localparam logic [3:0] S_T_STAT  = 4'd6;
  localparam logic [3:0] S_T_VEC   = 4'd7;
  localparam logic [3:0] S_M_STAT  = 4'd8;
  localparam logic [3:0] S_M_EPC   = 4'd9;

  logic [3:0]        r_state;
  logic [2:0]        r_op;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_src;
  logic [4:0]        r_idx;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_cause;
  logic [XLEN-1:0]   r_tval;
  logic [XLEN-1:0]   r_old;
  logic              r_ill;

  logic              w_bad_op;
  logic              w_wr;
  logic              w_ill;
  logic [XLEN-1:0]   w_new;
  logic [XLEN-1:0]   w_trap_stat;
  logic [XLEN-1:0]   w_mret_stat;
  logic [XLEN-1:0]   w_vec_pc;

  // op[1:0]: 01 write, 10 set, 11 clear, 00 reserved; op[2] selects the zimm form
  assign w_bad_op = r_op[1:0] == 2'b00;
  // set/clear with rs1/zimm of zero must not write, which also keeps it legal on read-only CSRs
  assign w_wr = !w_bad_op && !(r_op[1] && r_idx == 5'd0);
  assign w_ill = w_bad_op || (w_wr && r_addr[CSR_AW-1:CSR_AW-2] == 2'b11);
  assign w_new = r_op[1:0] == 2'b01 ? r_src :
                 r_op[1:0] == 2'b10 ? (csr_rdata_i | r_src) : (csr_rdata_i & ~r_src);
  // trap: stack IE into IE1 and disable; MRET: restore IE from IE1 and set IE1
  assign w_trap_stat = {csr_rdata_i[XLEN-1:4], csr_rdata_i[0], csr_rdata_i[2:1], 1'b0};
  assign w_mret_stat = {csr_rdata_i[XLEN-1:4], 1'b1, csr_rdata_i[2:1], csr_rdata_i[3]};
  assign w_vec_pc = {csr_rdata_i[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op <= '0;
      r_addr <= '0;
      r_src <= '0;
      r_idx <= '0;
      r_pc <= '0;
      r_cause <= '0;
      r_tval <= '0;
      r_old <= '0;
      r_ill <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trap_valid_i) begin
            r_pc <= trap_pc_i;
            r_cause <= trap_cause_i;
            r_tval <= trap_tval_i;
            r_state <= S_T_EPC;
          end else if (mret_i) begin
            r_state <= S_M_STAT;
          end else if (req_valid_i) begin
            r_op <= op_i;
            r_addr <= csr_addr_i;
            r_src <= op_i[2] ? XLEN'(rs1_idx_i) : rs1_data_i;
            r_idx <= rs1_idx_i;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_old <= w_ill ? '0 : csr_rdata_i;
          r_ill <= w_ill;
          r_state <= S_DONE;
        end
        S_T_EPC:   r_state <= S_T_CAUSE;
        S_T_CAUSE: r_state <= S_T_TVAL;
        S_T_TVAL:  r_state <= S_T_STAT;
        S_T_STAT:  r_state <= S_T_VEC;
        S_M_STAT:  r_state <= S_M_EPC;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we_o = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    case (r_state)
      S_EXEC: begin
        csr_we_o = w_wr && !w_ill;
        csr_waddr_o = csr_we_o ? r_addr : '0;
        csr_wdata_o = csr_we_o ? w_new : '0;
      end
      S_T_EPC: begin
        csr_we_o = 1'b1;
        csr_waddr_o = A_MEPC;
        csr_wdata_o = r_pc;
      end
      S_T_CAUSE: begin
        csr_we_o = 1'b1;
        csr_waddr_o = A_MCAUSE;
        csr_wdata_o = r_cause;
      end
      S_T_TVAL: begin
        csr_we_o = 1'b1;
        csr_waddr_o = A_MTVAL;
        csr_wdata_o = r_tval;
      end
      S_T_STAT: begin
        csr_we_o = 1'b1;
        csr_waddr_o = A_MSTATUS;
        csr_wdata_o = w_trap_stat;
      end
      S_M_STAT: begin
        csr_we_o = 1'b1;
        csr_waddr_o = A_MSTATUS;
        csr_wdata_o = w_mret_stat;
      end
      default: ;
    endcase
  end

  assign req_ready_o = r_state == S_IDLE;
  assign csr_raddr_o = r_state == S_EXEC ? r_addr :
                       (r_state == S_T_STAT || r_state == S_M_STAT) ? A_MSTATUS :
                       r_state == S_T_VEC ? A_MTVEC :
                       r_state == S_M_EPC ? A_MEPC : '0;
  assign resp_valid_o = r_state == S_DONE;
  assign resp_rdata_o = r_state == S_DONE ? r_old : '0;
  assign resp_illegal_o = r_state == S_DONE && r_ill;
  assign redirect_valid_o = r_state == S_T_VEC || r_state == S_M_EPC;
  assign redirect_pc_o = redirect_valid_o ? w_vec_pc : '0;
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: scoreboard bench for csr_ctrl with a behavioural CSR file
module tb_csr_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  op_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [63:0] rs1_data_i = '0;
  logic [4:0]  rs1_idx_i = '0;
  logic        resp_valid_o;
  logic [63:0] resp_rdata_o;
  logic        resp_illegal_o;
  logic        trap_valid_i = 1'b0;
  logic [63:0] trap_cause_i = '0;
  logic [63:0] trap_pc_i = '0;
  logic [63:0] trap_tval_i = '0;
  logic        mret_i = 1'b0;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o;
  logic [11:0] csr_raddr_o;
  logic [63:0] csr_rdata_i;

  csr_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .op_i(op_i),
    .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i), .rs1_idx_i(rs1_idx_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_illegal_o(resp_illegal_o),
    .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    int          c;
    logic [11:0] a;
    logic [63:0] d;
    logic        il;
  } ev_t;

  ev_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [63:0] mem [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  assign csr_rdata_i = mem[csr_raddr_o];

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[12'h300] <= 64'h1;
      mem[12'h305] <= 64'h8000_0003;
      mem[12'h340] <= 64'h0;
      mem[12'h341] <= 64'h0;
      mem[12'h342] <= 64'h0;
      mem[12'h343] <= 64'h0;
      mem[12'hF11] <= 64'h489;
      mem[12'hF14] <= 64'h7;
    end else if (csr_we_o) begin
      mem[csr_waddr_o] <= csr_wdata_o;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input int k, input logic [11:0] a, input logic [63:0] d, input logic il);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d cyc=%0d addr=%h data=%h ill=%b", k, cyc, a, d, il);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.c != cyc || e.a !== a || e.d !== d || e.il !== il) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d addr=%h data=%h ill=%b expected kind=%0d cyc=%0d addr=%h data=%h ill=%b",
                 k, cyc, a, d, il, e.k, e.c, e.a, e.d, e.il);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (csr_we_o) chk_ev(0, csr_waddr_o, csr_wdata_o, 1'b0);
      if (resp_valid_o) chk_ev(1, 12'h0, resp_rdata_o, resp_illegal_o);
      if (redirect_valid_o) chk_ev(2, 12'h0, redirect_pc_o, 1'b0);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!req_ready_o && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!req_ready_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready_o=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic do_csr(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] data,
                        input logic [4:0] idx, input bit we, input logic [63:0] wd,
                        input logic [63:0] rd, input logic ill);
    int n;
    wait_ready();
    req_valid_i = 1'b1;
    op_i = op;
    csr_addr_i = addr;
    rs1_data_i = data;
    rs1_idx_i = idx;
    n = cyc;
    if (we) q.push_back('{k: 0, c: n + 1, a: addr, d: wd, il: 1'b0});
    q.push_back('{k: 1, c: n + 2, a: 12'h0, d: rd, il: ill});
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval,
                         input logic [63:0] stat, input logic [63:0] vec, input int keep, input bit all);
    int n;
    ev_t e[5];
    wait_ready();
    trap_valid_i = 1'b1;
    trap_pc_i = pc;
    trap_cause_i = cause;
    trap_tval_i = tval;
    mret_i = all;
    req_valid_i = all;
    op_i = 3'b001;
    csr_addr_i = 12'h340;
    rs1_data_i = 64'hBAD;
    rs1_idx_i = 5'd1;
    n = cyc;
    e[0] = '{k: 0, c: n + 1, a: 12'h341, d: pc, il: 1'b0};
    e[1] = '{k: 0, c: n + 2, a: 12'h342, d: cause, il: 1'b0};
    e[2] = '{k: 0, c: n + 3, a: 12'h343, d: tval, il: 1'b0};
    e[3] = '{k: 0, c: n + 4, a: 12'h300, d: stat, il: 1'b0};
    e[4] = '{k: 2, c: n + 5, a: 12'h0, d: vec, il: 1'b0};
    for (int i = 0; i < keep; i++) q.push_back(e[i]);
    @(posedge clk);
    #1;
    trap_valid_i = 1'b0;
    mret_i = 1'b0;
    req_valid_i = 1'b0;
  endtask

  task automatic do_mret(input logic [63:0] stat, input logic [63:0] pc);
    int n;
    wait_ready();
    mret_i = 1'b1;
    n = cyc;
    q.push_back('{k: 0, c: n + 1, a: 12'h300, d: stat, il: 1'b0});
    q.push_back('{k: 2, c: n + 2, a: 12'h0, d: pc, il: 1'b0});
    @(posedge clk);
    #1;
    mret_i = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'h1);
    chk({tag, "_we"}, {63'h0, csr_we_o}, 64'h0);
    chk({tag, "_waddr"}, 64'(csr_waddr_o), 64'h0);
    chk({tag, "_wdata"}, csr_wdata_o, 64'h0);
    chk({tag, "_raddr"}, 64'(csr_raddr_o), 64'h0);
    chk({tag, "_resp"}, {62'h0, resp_valid_o, resp_illegal_o}, 64'h0);
    chk({tag, "_rdata"}, resp_rdata_o, 64'h0);
    chk({tag, "_redir"}, {63'h0, redirect_valid_o}, 64'h0);
    chk({tag, "_rpc"}, redirect_pc_o, 64'h0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("reset");
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    do_csr(3'b001, 12'h340, 64'hDEADBEEF_00000001, 5'd1, 1'b1, 64'hDEADBEEF_00000001, 64'h0, 1'b0);
    do_csr(3'b010, 12'h340, 64'h10, 5'd5, 1'b1, 64'hDEADBEEF_00000011, 64'hDEADBEEF_00000001, 1'b0);
    do_csr(3'b111, 12'h340, 64'h0, 5'd17, 1'b1, 64'hDEADBEEF_00000000, 64'hDEADBEEF_00000011, 1'b0);
    do_csr(3'b101, 12'h340, 64'hFFFF, 5'd31, 1'b1, 64'h1F, 64'hDEADBEEF_00000000, 1'b0);
    do_csr(3'b110, 12'h300, 64'h0, 5'd0, 1'b0, 64'h0, 64'h1, 1'b0);
    do_csr(3'b010, 12'hF11, 64'hFF, 5'd0, 1'b0, 64'h0, 64'h489, 1'b0);
    do_csr(3'b001, 12'hF14, 64'h55, 5'd3, 1'b0, 64'h0, 64'h0, 1'b1);
    do_csr(3'b100, 12'h340, 64'h1, 5'd1, 1'b0, 64'h0, 64'h0, 1'b1);
    do_trap(64'h8000_0104, 64'hB, 64'h0, 64'h8, 64'h8000_0000, 5, 1'b0);
    do_mret(64'h9, 64'h8000_0104);
    do_trap(64'h8000_0200, 64'h2, 64'h1234, 64'h8, 64'h8000_0000, 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("busy_ready", 64'(req_ready_o), 64'h0);
      @(posedge clk);
      #1;
    end
    chk("back_ready", 64'(req_ready_o), 64'h1);
    do_trap(64'h8000_0300, 64'h3, 64'h5, 64'h8, 64'h8000_0000, 2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_idle_outs("midrst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mtval_kept", mem[12'h343], 64'h1234);
    chk("mstatus_kept", mem[12'h300], 64'h8);
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_event: got none expected kind=%0d cyc=%0d addr=%h data=%h", e.k, e.c, e.a, e.d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
